// File: rtl/alu_sched_pkg.sv
// Shared types for the alu_sched block: alu opcodes, scheduler states and the
// opcode legality helper used when ALU_SCHED_OPCHK_EN is defined.
package alu_sched_pkg;

    typedef enum logic [2:0] {
        OP_PASS = 3'b001,
        OP_ADD  = 3'b010,
        OP_MUL  = 3'b100
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } sched_state_t;

    localparam int NREQ_MAX = 2;

    function automatic logic op_legal(input logic [2:0] ctrl);
        return (ctrl == OP_PASS) || (ctrl == OP_ADD) || (ctrl == OP_MUL);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: the requester that did not win last time has
// priority; a lone requester always wins. Purely combinational, one-hot grant.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] gnt
);

    assign gnt[0] = en & req[0] & (~req[1] |  last_grant);
    assign gnt[1] = en & req[1] & (~req[0] | ~last_grant);

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one external combinational alu between two
// requesters. Optional ALU_SCHED_OPCHK_EN flags illegal opcodes via rsp_err.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NREQ       = NREQ_MAX
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*DATA_WIDTH-1:0] req_a,
    input  logic [NREQ*DATA_WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]          req_ctrl,
    output logic [DATA_WIDTH-1:0]      alu_a,
    output logic [DATA_WIDTH-1:0]      alu_b,
    output logic [2:0]                 alu_ctrl,
    input  logic [DATA_WIDTH-1:0]      alu_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic                       rsp_id,
    output logic                       rsp_err
);

    sched_state_t          state_q, state_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]            alu_ctrl_q, alu_ctrl_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_id_q, rsp_id_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [1:0]            gnt;
    logic                  win;
    logic                  sel_bad;
    logic [2:0]            sel_ctrl;

    logic [DATA_WIDTH-1:0] a_arr    [NREQ];
    logic [DATA_WIDTH-1:0] b_arr    [NREQ];
    logic [2:0]            ctrl_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i]    = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        assign b_arr[i]    = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        assign ctrl_arr[i] = req_ctrl[i*3 +: 3];
    end

    rr_arbiter2 u_arb (
        .req        (req_valid),
        .last_grant (last_q),
        .en         (state_q == IDLE),
        .gnt        (gnt)
    );

    assign win = gnt[1];

`ifdef ALU_SCHED_OPCHK_EN
    // Illegal opcodes are executed as pass-B so the response still carries B.
    assign sel_bad  = ~op_legal(ctrl_arr[win]);
    assign sel_ctrl = sel_bad ? OP_PASS : ctrl_arr[win];
`else
    assign sel_bad  = 1'b0;
    assign sel_ctrl = ctrl_arr[win];
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                req_ready = gnt;
                if (|gnt) begin
                    alu_a_d    = a_arr[win];
                    alu_b_d    = b_arr[win];
                    alu_ctrl_d = sel_ctrl;
                    rsp_id_d   = win;
                    rsp_err_d  = sel_bad;
                    last_d     = win;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_result;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= OP_PASS;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

endmodule
